// File: rtl/add16_nibble_seq.sv
// Multi-cycle WIDTH-bit adder that drives one external SLICE-bit ripple slice per cycle, lowest slice first.
// Optional subtract mode (req_sub port) is enabled by defining ADD16_SEQ_SUB_EN.
module add16_nibble_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
`ifdef ADD16_SEQ_SUB_EN
  input  logic             req_sub,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic [SLICE-1:0] slc_a,
  output logic [SLICE-1:0] slc_b,
  output logic             slc_ci,
  input  logic [SLICE-1:0] slc_s,
  input  logic             slc_co,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_req_ready;
  logic             r_res_valid;
  logic             r_busy;
  logic [SLICE-1:0] r_slc_a;
  logic [SLICE-1:0] r_slc_b;
  logic             r_slc_ci;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic             w_last;
  logic [31:0]      w_base;
  logic [31:0]      w_base_nxt;
  logic [SLICE-1:0] w_a_nxt;
  logic [SLICE-1:0] w_b_nxt;

  // Subtract is A + ~B + 1; the inversion is folded in at accept so the slice loop stays add-only
`ifdef ADD16_SEQ_SUB_EN
  assign w_b_in   = req_sub ? ~req_b : req_b;
  assign w_cin_in = req_sub ? 1'b1 : req_cin;
`else
  assign w_b_in   = req_b;
  assign w_cin_in = req_cin;
`endif

  assign w_last     = (r_idx == IDX_W'(NSLICE - 1));
  assign w_base     = 32'(r_idx) * SLICE;
  assign w_base_nxt = w_base + SLICE;
  assign w_a_nxt    = SLICE'(r_a >> w_base_nxt);
  assign w_b_nxt    = SLICE'(r_b >> w_base_nxt);

  // Sequencer; slice drive is registered one nibble ahead so slc_* come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_co        <= 1'b0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_slc_a     <= '0;
      r_slc_b     <= '0;
      r_slc_ci    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_a         <= req_a;
            r_b         <= w_b_in;
            r_carry     <= w_cin_in;
            r_idx       <= '0;
            r_state     <= S_RUN;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_slc_a     <= req_a[SLICE-1:0];
            r_slc_b     <= w_b_in[SLICE-1:0];
            r_slc_ci    <= w_cin_in;
          end
        end
        S_RUN: begin
          r_sum[w_base +: SLICE] <= slc_s;
          r_carry                <= slc_co;
          if (w_last) begin
            r_state     <= S_DONE;
            r_co        <= slc_co;
            r_res_valid <= 1'b1;
            r_slc_a     <= '0;
            r_slc_b     <= '0;
            r_slc_ci    <= 1'b0;
          end else begin
            r_idx    <= r_idx + IDX_W'(1);
            r_slc_a  <= w_a_nxt;
            r_slc_b  <= w_b_nxt;
            r_slc_ci <= slc_co;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_res_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_slc_a     <= '0;
          r_slc_b     <= '0;
          r_slc_ci    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;
  assign res_sum   = r_sum;
  assign res_co    = r_co;
  assign slc_a     = r_slc_a;
  assign slc_b     = r_slc_b;
  assign slc_ci    = r_slc_ci;

endmodule

// File: tb/tb_add16_nibble_seq.sv
// Bench for add16_nibble_seq: behavioural 4-bit slice, vector table plus handshake/reset corner sequences.
module tb_add16_nibble_seq;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             req_cin = 1'b0;
`ifdef ADD16_SEQ_SUB_EN
  logic             req_sub = 1'b0;
`endif
  logic [SLICE-1:0] slc_a;
  logic [SLICE-1:0] slc_b;
  logic             slc_ci;
  logic [SLICE-1:0] slc_s;
  logic             slc_co;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_sum;
  logic             res_co;
  logic             busy;

  add16_nibble_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
`ifdef ADD16_SEQ_SUB_EN
    .req_sub   (req_sub),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .slc_a     (slc_a),
    .slc_b     (slc_b),
    .slc_ci    (slc_ci),
    .slc_s     (slc_s),
    .slc_co    (slc_co),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_co    (res_co),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External 4-bit carry-propagate slice
  assign {slc_co, slc_s} = 5'(slc_a) + 5'(slc_b) + 5'(slc_ci);

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             co;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   run_cycles;
  logic ci_log [NSLICE];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, input logic [15:0] s, input logic co);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.co = co;
    return v;
  endfunction

  task automatic send(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_a = v.a;
    req_b = v.b;
    req_cin = v.cin;
`ifdef ADD16_SEQ_SUB_EN
    req_sub = v.sub;
`endif
    req_valid = 1'b1;
    @(posedge clk);
    e.s = v.s;
    e.co = v.co;
    sb.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  // Waits for res_valid; records slc_ci per RUN cycle and can inject a stray request
  task automatic wait_res(input bit pulse);
    bit found = 1'b0;
    run_cycles = 0;
    for (int k = 0; k < NSLICE; k++) ci_log[k] = 1'bx;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (res_valid) begin
        found = 1'b1;
      end else begin
        if (run_cycles < NSLICE) ci_log[run_cycles] = slc_ci;
        if (pulse && run_cycles == 1) begin
          req_a = 16'hDEAD;
          req_b = 16'hBEEF;
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
        run_cycles++;
      end
    end
    req_valid = 1'b0;
    chk("result_latency", 32'(run_cycles), 32'(NSLICE));
  endtask

  task automatic take(input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: result present with no expected entry");
      return;
    end
    e = sb[0];
    for (int h = 0; h < hold; h++) begin
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_sum", 32'(res_sum), 32'(e.s));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_sum", 32'(res_sum), 32'(e.s));
    chk("res_co", 32'(res_co), 32'(e.co));
    chk("busy_in_done", 32'(busy), 32'd1);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_after_take", 32'(res_valid), 32'd0);
    chk("req_ready_after_take", 32'(req_ready), 32'd1);
    chk("res_sum_kept", 32'(res_sum), 32'(e.s));
    chk("slc_a_idle", 32'(slc_a), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    chk("rst_res_co", 32'(res_co), 32'd0);
    chk("rst_slc", 32'({slc_a, slc_b, slc_ci}), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [16:0] full;

    tbl.push_back(mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0));
    tbl.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(mk(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0));
    tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1));
    tbl.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0));
    tbl.push_back(mk(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0));
`ifdef ADD16_SEQ_SUB_EN
    tbl.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0));
    tbl.push_back(mk(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1));
    tbl.push_back(mk(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1));
`endif

    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      send(tbl[i]);
      wait_res(1'b0);
      if (tbl[i].a == 16'hFFFF && tbl[i].b == 16'h0001) begin
        chk("ci_run1", 32'(ci_log[0]), 32'd0);
        chk("ci_run2", 32'(ci_log[1]), 32'd1);
        chk("ci_run3", 32'(ci_log[2]), 32'd1);
        chk("ci_run4", 32'(ci_log[3]), 32'd1);
      end
      take(0);
    end

    // Backpressure in DONE plus a stray request during RUN
    send(mk(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0));
    wait_res(1'b1);
    take(3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stray_req_dropped", 32'(res_valid), 32'd0);
      chk("stray_req_idle", 32'(busy), 32'd0);
    end

    // Reset in the second RUN cycle discards the add
    send(mk(16'h4444, 16'h1111, 1'b0, 1'b0, 16'h5555, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_reset_no_valid", 32'(res_valid), 32'd0);
      chk("post_reset_ready", 32'(req_ready), 32'd1);
    end

    // Random adds against a 17-bit arithmetic model
    for (int k = 0; k < 6; k++) begin
      v.a = 16'($urandom);
      v.b = 16'($urandom);
      v.cin = 1'($urandom_range(1, 0));
      v.sub = 1'b0;
      full = 17'(v.a) + 17'(v.b) + 17'(v.cin);
      v.s = full[15:0];
      v.co = full[16];
      send(v);
      wait_res(1'b0);
      take(k % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
